// File: rtl/sram_burst_reader.sv
// Burst read initiator: one-word-at-a-time reads on the SRAM req/ack port into a FWFT word FIFO.
// Latency: accept -> first mem_req 1 cycle; per word L+2 cycles; word visible 1 cycle after capture.
// Backpressure: reads are issued only with a guaranteed free FIFO slot. Optional abort: SRAM_RDR_ABORT_EN.
module sram_burst_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [7:0]                  cmd_len,
`ifdef SRAM_RDR_ABORT_EN
  input  logic                        cmd_abort,
`endif
  output logic                        busy,
  output logic                        done,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata,
  input  logic                        mem_ack,
  input  logic                        mem_ready,
  output logic                        out_valid,
  output logic [31:0]                 out_data,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_reg, addr_nxt;
  logic [8:0]        remaining, remaining_nxt;
  logic              abort_flag, abort_flag_nxt;
  logic              abort_in;
  logic              push, pop, flush;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;

`ifdef SRAM_RDR_ABORT_EN
  assign abort_in = cmd_abort;
`else
  assign abort_in = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign mem_addr  = addr_reg;
  assign mem_we    = 1'b0;
  assign mem_wdata = 32'd0;
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 32'd0;
  assign fifo_level = level;
  assign pop       = out_valid && out_ready;

  // Next-state and outputs. The credit check uses the registered level only; a pop in
  // the same cycle is not credited, which can delay a request by at most one cycle.
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_reg;
    remaining_nxt  = remaining;
    abort_flag_nxt = abort_flag;
    cmd_ready      = 1'b0;
    mem_req        = 1'b0;
    push           = 1'b0;
    flush          = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready      = 1'b1;
        abort_flag_nxt = 1'b0;
        if (cmd_valid) begin
          addr_nxt      = cmd_addr;
          remaining_nxt = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (abort_in) begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end else if (mem_ready && (level < DEPTH_L)) begin
          mem_req   = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (abort_in) abort_flag_nxt = 1'b1;
        if (mem_ack) begin
          if (abort_flag || abort_in) begin
            // aborted: the returning word is dropped
            flush          = 1'b1;
            abort_flag_nxt = 1'b0;
            state_nxt      = IDLE;
          end else begin
            state_nxt = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        push          = 1'b1;
        addr_nxt      = addr_reg + ADDR_W'(1);
        remaining_nxt = remaining - 9'd1;
        if (abort_in) begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end else if (remaining == 9'd1) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_reg   <= '0;
      remaining  <= '0;
      abort_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_reg   <= addr_nxt;
      remaining  <= remaining_nxt;
      abort_flag <= abort_flag_nxt;
    end
  end

  // FIFO pointers and occupancy; an abort flush wins over a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents are only observable through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;

  localparam int DEPTH = 16;
  localparam int AW    = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
`ifdef SRAM_RDR_ABORT_EN
  logic          cmd_abort;
`endif
  logic          busy, done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic          mem_ack = 1'b0;
  logic          mem_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready;
  logic [$clog2(DEPTH):0] fifo_level;

  int errors = 0;
  int checks = 0;

  sram_burst_reader #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef SRAM_RDR_ABORT_EN
    .cmd_abort(cmd_abort),
`endif
    .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_ready(mem_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Responder: acks rsp_lat cycles after a request, data follows one cycle after the ack.
  int            rsp_lat = 1;
  logic          rsp_fixed = 1'b0;
  logic [31:0]   rsp_word = 32'd0;
  int            rsp_cnt = 0;
  logic          rsp_pend = 1'b0;
  logic [AW-1:0] rsp_addr = '0;
  int            req_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] req_log [$];

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rsp_pend) begin
      mem_rdata = rsp_fixed ? rsp_word : {8'h5A, rsp_addr};
      rsp_pend  = 1'b0;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_ack  = 1'b1;
        rsp_pend = 1'b1;
      end
    end
    if (mem_req) begin
      rsp_cnt  = rsp_lat;
      rsp_addr = mem_addr;
      req_cnt++;
      req_log.push_back(mem_addr);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_reaches_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_log();
    req_cnt  = 0;
    done_cnt = 0;
    req_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, popped, bad, hi, n, seen;
    logic [31:0] exp_w;
    logic [AW-1:0] exp_a;

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
    mem_ready = 1'b1; out_ready = 1'b0;
`ifdef SRAM_RDR_ABORT_EN
    cmd_abort = 1'b0;
`endif
    repeat (3) tick();

    // reset state
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fifo_level", {27'd0, fifo_level}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    rst = 1'b0;
    tick();

    // single word, ack 3 cycles after request
    clear_log();
    rsp_lat = 3; rsp_fixed = 1'b1; rsp_word = 32'hDEADBEEF;
    cmd_valid = 1'b1; cmd_addr = 24'h000123; cmd_len = 8'd1;
    tick();
    cmd_valid = 1'b0;
    check("t1_first_req", {31'd0, mem_req}, 32'd1);
    check("t1_req_addr", {8'd0, mem_addr}, 32'h000123);
    check("t1_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      if (done) lat = i + 1;   // cycles counted from the accept cycle through the done cycle
      else tick();
    end
    check("t1_accept_to_done", lat, 32'd6);
    tick();
    check("t1_busy_falls", {31'd0, busy}, 32'd0);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_data", out_data, 32'hDEADBEEF);
    repeat (3) tick();
    check("t1_req_count", req_cnt, 32'd1);
    check("t1_done_count", done_cnt, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_drained", {27'd0, fifo_level}, 32'd0);
    rsp_fixed = 1'b0;

    // backpressure: 40 words with the consumer stalled
    clear_log();
    rsp_lat = 1;
    cmd_valid = 1'b1; cmd_addr = 24'h000100; cmd_len = 8'd40;
    tick();
    cmd_valid = 1'b0;
    repeat (100) tick();
    check("t2_req_count_stalled", req_cnt, 32'd16);
    check("t2_level_full", {27'd0, fifo_level}, 32'd16);
    check("t2_req_low", {31'd0, mem_req}, 32'd0);
    check("t2_busy_stalled", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    popped = 0; bad = 0;
    for (int k = 0; k < 800 && popped < 40; k++) begin
      if (out_valid) begin
        exp_w = {8'h5A, 24'(24'h000100 + popped)};
        if (out_data !== exp_w) bad++;
        popped++;
      end
      tick();
    end
    check("t2_popped", popped, 32'd40);
    check("t2_data_order_errs", bad, 32'd0);
    wait_idle("t2", 200);
    repeat (2) tick();
    check("t2_empty_after", {31'd0, out_valid}, 32'd0);
    check("t2_req_total", req_cnt, 32'd40);
    check("t2_done_count", done_cnt, 32'd1);
    bad = 0;
    for (int k = 0; k < req_log.size(); k++)
      if (req_log[k] !== 24'(24'h000100 + k)) bad++;
    check("t2_addr_order_errs", bad, 32'd0);

    // address wrap with length 0 (256 words)
    clear_log();
    cmd_valid = 1'b1; cmd_addr = 24'hFFFFFE; cmd_len = 8'd0;
    tick();
    cmd_valid = 1'b0;
    wait_idle("t3", 1500);
    repeat (2) tick();
    check("t3_req_count", req_cnt, 32'd256);
    check("t3_done_count", done_cnt, 32'd1);
    check("t3_addr0", {8'd0, req_log[0]}, 32'hFFFFFE);
    check("t3_addr1", {8'd0, req_log[1]}, 32'hFFFFFF);
    check("t3_addr2", {8'd0, req_log[2]}, 32'h000000);
    check("t3_addr255", {8'd0, req_log[255]}, 32'h0000FD);
    bad = 0;
    for (int k = 0; k < req_log.size(); k++) begin
      exp_a = 24'hFFFFFE + AW'(k);
      if (req_log[k] !== exp_a) bad++;
    end
    check("t3_addr_order_errs", bad, 32'd0);

    // mem_ready held low in ISSUE
    clear_log();
    mem_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 24'h000042; cmd_len = 8'd1;
    tick();
    cmd_valid = 1'b0;
    hi = 0;
    repeat (10) begin
      if (mem_req) hi++;
      tick();
    end
    check("t4_req_while_not_ready", hi, 32'd0);
    check("t4_busy_waiting", {31'd0, busy}, 32'd1);
    mem_ready = 1'b1;
    #1;
    check("t4_req_on_ready", {31'd0, mem_req}, 32'd1);
    check("t4_req_addr", {8'd0, mem_addr}, 32'h000042);
    wait_idle("t4", 50);
    repeat (3) tick();
    check("t4_req_count", req_cnt, 32'd1);

    // reset during WAIT_ACK with 5 words queued
    clear_log();
    out_ready = 1'b0;
    rsp_lat = 4;
    cmd_valid = 1'b1; cmd_addr = 24'h000200; cmd_len = 8'd8;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(fifo_level == 5 && mem_req) && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("t5_in_wait_ack", {31'd0, mem_req}, 32'd0);
    check("t5_queued", {27'd0, fifo_level}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_idle_after_rst", {31'd0, cmd_ready}, 32'd1);
    check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    check("t5_level_after_rst", {27'd0, fifo_level}, 32'd0);
    check("t5_valid_after_rst", {31'd0, out_valid}, 32'd0);
    repeat (10) tick();
    check("t5_late_ack_level", {27'd0, fifo_level}, 32'd0);
    check("t5_late_ack_busy", {31'd0, busy}, 32'd0);

`ifdef SRAM_RDR_ABORT_EN
    // abort in WAIT_ACK of word 3
    repeat (5) tick();
    clear_log();
    cmd_valid = 1'b1; cmd_addr = 24'h000300; cmd_len = 8'd8;
    tick();
    cmd_valid = 1'b0;
    seen = 0; n = 0;
    while (seen < 3 && n < 200) begin
      if (mem_req) seen++;
      if (seen < 3) tick();
      n++;
    end
    tick();
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("t6_waits_for_ack", {31'd0, busy}, 32'd1);
    wait_idle("t6", 50);
    repeat (5) tick();
    check("t6_level_flushed", {27'd0, fifo_level}, 32'd0);
    check("t6_no_done", done_cnt, 32'd0);
    check("t6_req_count", req_cnt, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_burst_reader.md
# sram_burst_reader

Burst read initiator for the 32-bit word port of the SRAM controller. It accepts a command (start word address and length), then issues one word read at a time on the controller's req/ack port. Returned words go into an internal first-word-fall-through FIFO, and consumers such as display scanout or texture fetch drain it through a valid/ready stream. It never over-commits the FIFO: a read is issued only when a free slot is guaranteed.

## Interface
Parameters:
- FIFO_DEPTH, 16, word FIFO depth; power of two, minimum 4.
- ADDR_W, 24, word address width.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  8  burst length in words; 0 encodes 256.
- cmd_abort  in  1  present only with SRAM_RDR_ABORT_EN.
- busy  out  1  high from command acceptance until return to IDLE.
- done  out  1  one-cycle pulse when the last word of a burst is written into the FIFO.
- mem_req  out  1  read request; high for exactly one cycle per word.
- mem_we  out  1  constant 0.
- mem_addr  out  ADDR_W  word address; held stable from mem_req until capture.
- mem_wdata  out  32  constant 0.
- mem_rdata  in  32  read data; valid the cycle after mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- mem_ready  in  1  responder idle; a request is issued only while this is high.
- out_valid  out  1  FIFO not empty.
- out_data  out  32  FIFO head word.
- out_ready  in  1  consumer pop; the pop happens when out_valid && out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, CAPTURE.
- IDLE
  - On accept: latch addr_reg = cmd_addr and remaining = (cmd_len==0 ? 256 : cmd_len).
  - Go to ISSUE.
- ISSUE
  - mem_req = mem_ready && (fifo_level + pops-not-yet-counted < FIFO_DEPTH). This is combinational, from registered state only plus mem_ready.
  - When mem_req is high, go to WAIT_ACK. Otherwise stay in ISSUE with mem_req low.
- WAIT_ACK
  - mem_req is low.
  - On mem_ack, go to CAPTURE.
  - No timeout; waits indefinitely.
- CAPTURE
  - Push mem_rdata into the FIFO.
  - addr_reg += 1, wrapping modulo 2^ADDR_W.
  - remaining -= 1.
  - If remaining reaches 0: pulse done and go to IDLE. Otherwise go to ISSUE.
- At most one request is outstanding at any time.
- FIFO behaviour:
  - A push in CAPTURE and a pop in the same cycle leave fifo_level unchanged.
  - A push can never find the FIFO full, because of the ISSUE credit check.
  - A pop while empty is ignored.
  - The FIFO persists across bursts, so a new command may start while older data is still queued.
- mem_addr = addr_reg at all times.
- mem_ack outside WAIT_ACK is ignored. This is a protocol error; no state change.

## Timing
- Reset values:
  - State IDLE.
  - cmd_ready = 1.
  - busy = 0, done = 0, mem_req = 0, mem_addr = 0.
  - FIFO empty: out_valid = 0, fifo_level = 0. out_data is undefined but held at 0.
- Reset mid-burst returns the block to IDLE and empties the FIFO. Any in-flight ack that arrives after reset is ignored.
- Accept edge to first mem_req: 1 cycle, if mem_ready is high and there is FIFO space.
- Per-word period: L+2 cycles for a responder that acks L cycles after req (ISSUE → L cycles of WAIT_ACK → CAPTURE).
- A word is visible on out_valid/out_data 1 cycle after CAPTURE.
- done pulses in the same cycle as the final CAPTURE. busy falls on the next cycle, when the block is back in IDLE.
- A new command can be accepted on the first IDLE cycle.

## Configuration
- Macro SRAM_RDR_ABORT_EN.
- Defined:
  - Adds the cmd_abort input, sampled every cycle while busy.
  - Abort in ISSUE: go to IDLE immediately.
  - Abort in WAIT_ACK: set an abort flag, wait for mem_ack, discard that word (no push), then go to IDLE.
  - Abort in CAPTURE: the push completes, then go to IDLE.
  - In all abort cases: flush the FIFO on the IDLE entry cycle, and do not pulse done.
  - Abort while in IDLE is ignored.
- Undefined: no cmd_abort port; every accepted burst runs to completion.

## Test plan
- Single word: cmd_addr=0x000123, cmd_len=1; model acks 3 cycles after req returning 0xDEADBEEF.
  - Required: exactly one mem_req with mem_addr=0x000123.
  - done pulses once; out_data=0xDEADBEEF.
  - Accept-to-done is 6 cycles.
- Backpressure: FIFO_DEPTH=16, cmd_len=40, out_ready=0.
  - Required: exactly 16 mem_req pulses, then mem_req stays low and fifo_level=16.
  - After releasing out_ready: all 40 words arrive in address order, with no lost or duplicated data.
- Wrap and length 0: cmd_addr=0xFFFFFE, cmd_len=0, out_ready=1.
  - Required: 256 requests; addresses run 0xFFFFFE, 0xFFFFFF, 0x000000 … 0x0000FD.
- mem_ready low: hold mem_ready=0 for 10 cycles in ISSUE.
  - Required: mem_req stays 0 for those cycles and is issued on the first cycle mem_ready=1.
- Reset mid-burst: assert rst while in WAIT_ACK with 5 words queued.
  - Required: next cycle is IDLE, fifo_level=0, out_valid=0; a late mem_ack produces no push.
- Abort (SRAM_RDR_ABORT_EN): cmd_len=8, abort asserted in WAIT_ACK of word 3.
  - Required: waits for the ack, then IDLE with fifo_level=0, no done pulse, and no 4th mem_req.
